top_n_bin_selector: RTL and testbench

TOP_N_BIN_SELECTOR -- requirements
Module: top_n_bin_selector

---
 rtl/top_n_bin_selector_pkg.sv | 30 +++
 rtl/bin_power_compute.sv | 64 ++++++
 rtl/top_n_bin_selector.sv | 181 ++++++++++++++++++
 tb/tb_top_n_bin_selector.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/top_n_bin_selector_pkg.sv
// Shared definitions for the top-N FFT bin selector: default sizes, the packed
// bin-entry layout and the squared-magnitude helper.
package top_n_bin_selector_pkg;

    localparam int NUM_HARMONICS = 5;
    localparam int FFT_SIZE      = 1024;
    localparam int BIN_IDX_W     = $clog2(FFT_SIZE);
    localparam int POWER_W       = 33;
    localparam int COEFF_W       = 32;

    typedef struct packed {
        logic [POWER_W-1:0]   power;
        logic [COEFF_W-1:0]   coeff;
        logic [BIN_IDX_W-1:0] index;
    } bin_entry_t;

    // re*re + im*im; each square is at most 2^30, so the 33-bit sum is exact.
    function automatic logic [POWER_W-1:0] bin_power(input logic [COEFF_W-1:0] coeff);
        logic signed [31:0] re;
        logic signed [31:0] im;
        logic [31:0]        re_sq;
        logic [31:0]        im_sq;
        re    = 32'($signed(coeff[31:16]));
        im    = 32'($signed(coeff[15:0]));
        re_sq = 32'(re * re);
        im_sq = 32'(im * im);
        return {1'b0, re_sq} + {1'b0, im_sq};
    endfunction

endpackage

// File: rtl/bin_power_compute.sv
// Stage 1 of the selector: registers the squared magnitude of one accepted bin
// together with its raw coefficient, bin index and frame-end flag.
module bin_power_compute #(
    parameter int IDX_W = top_n_bin_selector_pkg::BIN_IDX_W
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             valid_in,
    input  logic [31:0]      coeff_in,
    input  logic [IDX_W-1:0] index_in,
    input  logic             last_in,
    output logic             valid_out,
    output logic [32:0]      power_out,
    output logic [31:0]      coeff_out,
    output logic [IDX_W-1:0] index_out,
    output logic             last_out
);
    import top_n_bin_selector_pkg::*;

    logic             valid_q, valid_d;
    logic [32:0]      power_q, power_d;
    logic [31:0]      coeff_q, coeff_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic             last_q, last_d;

    // Next-state: capture a new bin when one is presented, otherwise hold the payload.
    always_comb begin
        valid_d = valid_in;
        last_d  = valid_in & last_in;
        if (valid_in) begin
            power_d = bin_power(coeff_in);
            coeff_d = coeff_in;
            index_d = index_in;
        end else begin
            power_d = power_q;
            coeff_d = coeff_q;
            index_d = index_q;
        end
    end

    // Stage-1 register with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_q <= 1'b0;
            power_q <= 33'd0;
            coeff_q <= 32'd0;
            index_q <= {IDX_W{1'b0}};
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            power_q <= power_d;
            coeff_q <= coeff_d;
            index_q <= index_d;
            last_q  <= last_d;
        end
    end

    assign valid_out = valid_q;
    assign power_out = power_q;
    assign coeff_out = coeff_q;
    assign index_out = index_q;
    assign last_out  = last_q;

endmodule

// File: rtl/top_n_bin_selector.sv
// Streams FFT bins, keeps the NUM_HARMONICS strongest eligible bins of each frame
// in a descending sorted list and presents that list once the frame's last bin lands.
module top_n_bin_selector #(
    parameter int NUM_HARMONICS = top_n_bin_selector_pkg::NUM_HARMONICS,
    parameter int FFT_SIZE      = top_n_bin_selector_pkg::FFT_SIZE
) (
    input  logic                                           clk_in,
    input  logic                                           rst_in,
    input  logic                                           fft_valid_in,
    input  logic [31:0]                                    fft_data_in,
    input  logic                                           fft_last_in,
    input  logic [32:0]                                    power_threshold_in,
    output logic [NUM_HARMONICS-1:0][31:0]                 top_n_coeffs,
    output logic [NUM_HARMONICS-1:0][$clog2(FFT_SIZE)-1:0] top_n_indices,
    output logic                                           valid_data_out
);
    localparam int               IDX_W      = $clog2(FFT_SIZE);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(FFT_SIZE - 1);
    localparam logic [IDX_W-1:0] MIRROR_IDX = IDX_W'(FFT_SIZE / 2);

    typedef struct packed {
        logic [32:0]      power;
        logic [31:0]      coeff;
        logic [IDX_W-1:0] index;
    } slot_t;

    // Acceptance stage: input beat plus its assigned bin index.
    logic             acc_valid_q, acc_valid_d;
    logic [31:0]      acc_data_q, acc_data_d;
    logic [IDX_W-1:0] acc_index_q, acc_index_d;
    logic             acc_last_q, acc_last_d;
    logic [IDX_W-1:0] bin_cnt_q, bin_cnt_d;

    // Stage 1 outputs.
    logic             s1_valid_s;
    logic [32:0]      s1_power_s;
    logic [31:0]      s1_coeff_s;
    logic [IDX_W-1:0] s1_index_s;
    logic             s1_last_s;

    // Stage 2: working list and presentation registers.
    slot_t                                work_q [NUM_HARMONICS];
    slot_t                                work_d [NUM_HARMONICS];
    slot_t                                base_s [NUM_HARMONICS];
    slot_t                                above_s [NUM_HARMONICS];
    slot_t                                cand_s;
    logic [NUM_HARMONICS-1:0]             beats_s;
    logic [NUM_HARMONICS-1:0]             prev_beats_s;
    logic                                 insert_s;
    logic                                 copy_pend_q, copy_pend_d;
    logic                                 valid_out_q, valid_out_d;
    logic [NUM_HARMONICS-1:0][31:0]       out_coeffs_q, out_coeffs_d;
    logic [NUM_HARMONICS-1:0][IDX_W-1:0]  out_indices_q, out_indices_d;

    // Acceptance: the bin counter restarts after a last beat and wraps at FFT_SIZE-1.
    always_comb begin
        acc_valid_d = fft_valid_in;
        acc_last_d  = fft_valid_in & fft_last_in;
        if (fft_valid_in) begin
            acc_data_d  = fft_data_in;
            acc_index_d = bin_cnt_q;
            if (fft_last_in || (bin_cnt_q == LAST_IDX)) begin
                bin_cnt_d = {IDX_W{1'b0}};
            end else begin
                bin_cnt_d = bin_cnt_q + IDX_W'(1);
            end
        end else begin
            acc_data_d  = acc_data_q;
            acc_index_d = acc_index_q;
            bin_cnt_d   = bin_cnt_q;
        end
    end

    bin_power_compute #(
        .IDX_W(IDX_W)
    ) u_power (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .valid_in (acc_valid_q),
        .coeff_in (acc_data_q),
        .index_in (acc_index_q),
        .last_in  (acc_last_q),
        .valid_out(s1_valid_s),
        .power_out(s1_power_s),
        .coeff_out(s1_coeff_s),
        .index_out(s1_index_s),
        .last_out (s1_last_s)
    );

    // Candidate qualification: DC and mirror bins never enter the list.
    always_comb begin
        cand_s.power = s1_power_s;
        cand_s.coeff = s1_coeff_s;
        cand_s.index = s1_index_s;
        insert_s = s1_valid_s
                 && (s1_index_s != {IDX_W{1'b0}})
                 && (s1_index_s < MIRROR_IDX)
                 && (s1_power_s > power_threshold_in);
    end

    // Parallel compare-and-shift. The list is built on an empty base when the
    // previous frame is being copied out this cycle, so both frames stay intact.
    // beats_s is monotonic over a sorted base, so a slot whose upper neighbour was
    // beaten takes that neighbour; the first beaten slot takes the candidate.
    always_comb begin
        for (int i = 0; i < NUM_HARMONICS; i++) begin
            if (copy_pend_q) begin
                base_s[i] = '0;
            end else begin
                base_s[i] = work_q[i];
            end
            beats_s[i] = insert_s && (cand_s.power > base_s[i].power);
        end
        prev_beats_s[0] = 1'b0;
        above_s[0]      = cand_s;
        for (int i = 1; i < NUM_HARMONICS; i++) begin
            prev_beats_s[i] = beats_s[i-1];
            above_s[i]      = base_s[i-1];
        end
        for (int i = 0; i < NUM_HARMONICS; i++) begin
            if (prev_beats_s[i]) begin
                work_d[i] = above_s[i];
            end else if (beats_s[i]) begin
                work_d[i] = cand_s;
            end else begin
                work_d[i] = base_s[i];
            end
        end
    end

    // Result presentation: copy the finished list one cycle after its last insertion.
    always_comb begin
        copy_pend_d = s1_valid_s & s1_last_s;
        valid_out_d = copy_pend_q;
        if (copy_pend_q) begin
            for (int i = 0; i < NUM_HARMONICS; i++) begin
                out_coeffs_d[i]  = work_q[i].coeff;
                out_indices_d[i] = work_q[i].index;
            end
        end else begin
            out_coeffs_d  = out_coeffs_q;
            out_indices_d = out_indices_q;
        end
    end

    // State registers with synchronous reset; a reset drops any frame in flight.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            acc_valid_q   <= 1'b0;
            acc_data_q    <= 32'd0;
            acc_index_q   <= {IDX_W{1'b0}};
            acc_last_q    <= 1'b0;
            bin_cnt_q     <= {IDX_W{1'b0}};
            copy_pend_q   <= 1'b0;
            valid_out_q   <= 1'b0;
            out_coeffs_q  <= '0;
            out_indices_q <= '0;
            for (int i = 0; i < NUM_HARMONICS; i++) begin
                work_q[i] <= '0;
            end
        end else begin
            acc_valid_q   <= acc_valid_d;
            acc_data_q    <= acc_data_d;
            acc_index_q   <= acc_index_d;
            acc_last_q    <= acc_last_d;
            bin_cnt_q     <= bin_cnt_d;
            copy_pend_q   <= copy_pend_d;
            valid_out_q   <= valid_out_d;
            out_coeffs_q  <= out_coeffs_d;
            out_indices_q <= out_indices_d;
            for (int i = 0; i < NUM_HARMONICS; i++) begin
                work_q[i] <= work_d[i];
            end
        end
    end

    assign top_n_coeffs   = out_coeffs_q;
    assign top_n_indices  = out_indices_q;
    assign valid_data_out = valid_out_q;

endmodule

// File: tb/tb_top_n_bin_selector.sv
// Bench for top_n_bin_selector: directed and random frames against a frame-level
// top-N selection model, checked on every cycle plus literal result checks.
module tb_top_n_bin_selector;

    localparam int N  = 5;
    localparam int FS = 1024;
    localparam int IW = 10;

    logic                   clk_in = 1'b0;
    logic                   rst_in = 1'b1;
    logic                   fft_valid_in = 1'b0;
    logic [31:0]            fft_data_in = 32'd0;
    logic                   fft_last_in = 1'b0;
    logic [32:0]            power_threshold_in = 33'd0;
    logic [N-1:0][31:0]     top_n_coeffs;
    logic [N-1:0][IW-1:0]   top_n_indices;
    logic                   valid_data_out;

    top_n_bin_selector #(.NUM_HARMONICS(N), .FFT_SIZE(FS)) dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .fft_valid_in      (fft_valid_in),
        .fft_data_in       (fft_data_in),
        .fft_last_in       (fft_last_in),
        .power_threshold_in(power_threshold_in),
        .top_n_coeffs      (top_n_coeffs),
        .top_n_indices     (top_n_indices),
        .valid_data_out    (valid_data_out)
    );

    initial forever #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    // ---------------- model state ----------------
    typedef struct {
        logic [32:0]   p;
        logic [31:0]   c;
        logic [IW-1:0] idx;
    } cand_t;

    cand_t                cands[$];
    int                   m_idx = 0;
    int                   pulse_q[$];
    logic [N-1:0][31:0]   res_c_q[$];
    logic [N-1:0][IW-1:0] res_i_q[$];
    logic [31:0]          frame_bins[int];

    // literal-check requests from the driver to the compare process
    int                   lit_seq = 0;
    string                lit_name;
    logic [N-1:0][31:0]   lit_c;
    logic [N-1:0][IW-1:0] lit_i;
    int                   lit_pulses;

    int  n_chk = 0;
    int  n_pass = 0;
    bit  chk_en = 1'b0;

    function automatic longint sq(input logic [15:0] v);
        longint s;
        s = longint'($signed(v));
        return s * s;
    endfunction

    // Frame end: stable top-N selection by descending power, earliest arrival first on ties.
    task automatic finish_frame(input int pulse_cyc);
        logic [N-1:0][31:0]   rc;
        logic [N-1:0][IW-1:0] ri;
        bit                   taken[$];
        int                   best;
        rc = '0;
        ri = '0;
        foreach (cands[j]) taken.push_back(1'b0);
        for (int k = 0; k < N; k++) begin
            best = -1;
            foreach (cands[j]) begin
                if (!taken[j] && (best < 0 || cands[j].p > cands[best].p)) best = j;
            end
            if (best >= 0) begin
                taken[best] = 1'b1;
                rc[k] = cands[best].c;
                ri[k] = cands[best].idx;
            end
        end
        res_c_q.push_back(rc);
        res_i_q.push_back(ri);
        pulse_q.push_back(pulse_cyc);
        cands.delete();
    endtask

    task automatic beat(input logic [31:0] d, input bit last);
        logic [32:0] p;
        cand_t       c;
        @(posedge clk_in); #1;
        rst_in       = 1'b0;
        fft_valid_in = 1'b1;
        fft_data_in  = d;
        fft_last_in  = last;
        p = 33'(sq(d[31:16]) + sq(d[15:0]));
        if (m_idx != 0 && m_idx < FS / 2 && p > power_threshold_in) begin
            c.p = p; c.c = d; c.idx = IW'(m_idx);
            cands.push_back(c);
        end
        if (last) begin
            finish_frame(cyc + 4);
            m_idx = 0;
        end else begin
            m_idx = (m_idx + 1) % FS;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk_in); #1;
            fft_valid_in = 1'b0;
            fft_last_in  = ($urandom_range(0, 1) == 1);
            fft_data_in  = $urandom;
        end
        fft_last_in = 1'b0;
    endtask

    task automatic send_frame(input int len, input bit with_last);
        for (int b = 0; b < len; b++) begin
            beat(frame_bins.exists(b) ? frame_bins[b] : 32'd0, with_last && (b == len - 1));
        end
        frame_bins.delete();
    endtask

    task automatic do_reset();
        @(posedge clk_in); #1;
        rst_in       = 1'b1;
        fft_valid_in = 1'b0;
        fft_last_in  = 1'b0;
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        cands.delete();
        m_idx = 0;
    endtask

    task automatic request_lit(input string name, input int pulses);
        idle(6);
        lit_name   = name;
        lit_pulses = pulses;
        lit_seq    = lit_seq + 1;
        @(negedge clk_in);
    endtask

    // ---------------- compare process ----------------
    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_chk = n_chk + 1;
        if (act === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    initial begin : compare
        logic [N-1:0][31:0]   cur_c;
        logic [N-1:0][IW-1:0] cur_i;
        bit                   exp_v;
        bit                   rst_seen;
        int                   lit_done;
        int                   pulse_cnt;
        cur_c = '0; cur_i = '0; rst_seen = 1'b0; lit_done = 0; pulse_cnt = 0;
        forever begin
            @(negedge clk_in);
            if (rst_seen) begin
                cur_c = '0;
                cur_i = '0;
            end
            rst_seen = rst_in;
            if (chk_en) begin
                exp_v = (pulse_q.size() > 0) && (pulse_q[0] == cyc);
                if (exp_v) begin
                    void'(pulse_q.pop_front());
                    cur_c = res_c_q.pop_front();
                    cur_i = res_i_q.pop_front();
                end
                if (valid_data_out) pulse_cnt = pulse_cnt + 1;
                chk("valid", 160'(valid_data_out), 160'(exp_v));
                chk("coeffs", 160'(top_n_coeffs), 160'(cur_c));
                chk("indices", 160'(top_n_indices), 160'(cur_i));
                if (lit_seq != lit_done) begin
                    lit_done = lit_seq;
                    chk({lit_name, "_coeffs"}, 160'(top_n_coeffs), 160'(lit_c));
                    chk({lit_name, "_indices"}, 160'(top_n_indices), 160'(lit_i));
                    chk({lit_name, "_pulses"}, 160'(pulse_cnt), 160'(lit_pulses));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : driver
        logic [31:0] d;
        int          len;
        int          mode;
        int          gap;
        repeat (3) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        chk_en = 1'b1;
        idle(2);

        // three peaks, threshold 0
        frame_bins[10] = 32'h0064_0000;
        frame_bins[20] = 32'h0000_00C8;
        frame_bins[30] = 32'h0032_0032;
        send_frame(FS, 1'b1);
        lit_c = '0; lit_i = '0;
        lit_c[0] = 32'h0000_00C8; lit_i[0] = IW'(20);
        lit_c[1] = 32'h0064_0000; lit_i[1] = IW'(10);
        lit_c[2] = 32'h0032_0032; lit_i[2] = IW'(30);
        request_lit("three_peaks", 1);

        // equal powers: earlier bins win
        for (int b = 5; b <= 12; b++) frame_bins[b] = 32'h0064_0000;
        send_frame(FS, 1'b1);
        lit_c = '0; lit_i = '0;
        for (int k = 0; k < N; k++) begin
            lit_c[k] = 32'h0064_0000;
            lit_i[k] = IW'(5 + k);
        end
        request_lit("ties", 2);

        // DC and mirror bins excluded
        frame_bins[0]   = 32'h03E8_0000;
        frame_bins[600] = 32'h03E8_0000;
        frame_bins[3]   = 32'h0001_0000;
        send_frame(FS, 1'b1);
        lit_c = '0; lit_i = '0;
        lit_c[0] = 32'h0001_0000; lit_i[0] = IW'(3);
        request_lit("dc_mirror", 3);

        // threshold is exclusive; short frame ended early
        power_threshold_in = 33'd10000;
        frame_bins[7] = 32'h0064_0000;
        frame_bins[9] = 32'h0064_0001;
        send_frame(16, 1'b1);
        lit_c = '0; lit_i = '0;
        lit_c[0] = 32'h0064_0001; lit_i[0] = IW'(9);
        request_lit("threshold", 4);
        power_threshold_in = 33'd0;

        // back-to-back frames
        frame_bins[100] = 32'h012C_0000;
        send_frame(256, 1'b1);
        frame_bins[200] = 32'h0000_FED4;
        send_frame(256, 1'b1);
        lit_c = '0; lit_i = '0;
        lit_c[0] = 32'h0000_FED4; lit_i[0] = IW'(200);
        request_lit("back_to_back", 6);

        // reset mid-frame, then a full frame
        frame_bins[50] = 32'h07D0_0000;
        send_frame(500, 1'b0);
        do_reset();
        frame_bins[1] = 32'h0005_0000;
        frame_bins[2] = 32'h0009_0000;
        send_frame(FS, 1'b1);
        lit_c = '0; lit_i = '0;
        lit_c[0] = 32'h0009_0000; lit_i[0] = IW'(2);
        lit_c[1] = 32'h0005_0000; lit_i[1] = IW'(1);
        request_lit("after_reset", 7);

        // random frames, including wrap past FFT_SIZE and back-to-back starts
        for (int f = 0; f < 12; f++) begin
            len  = (f == 3) ? FS + 40 : $urandom_range(1, 700);
            mode = $urandom_range(0, 2);
            for (int b = 0; b < len; b++) begin
                case (mode)
                    0: d = ($urandom_range(0, 9) == 0) ? $urandom : 32'd0;
                    1: d = {16'($urandom_range(0, 3) * 37), 16'd0};
                    default: d = $urandom;
                endcase
                beat(d, b == len - 1);
            end
            gap = $urandom_range(0, 3);
            if (gap != 0) begin
                idle(3 + gap);
                power_threshold_in = ($urandom_range(0, 1) == 1) ? 33'($urandom_range(0, 5000000)) : 33'd0;
            end
        end
        idle(8);
        @(negedge clk_in);
        @(negedge clk_in);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
